// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port RAM with clear engine.
// Parity storage is only built when RAM_PARITY_EN is defined.
package ram_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int PAR_MAX_W = 64;

  function automatic logic lane_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

  function automatic bit lane_cfg_ok(input int data_w, input int lane_w);
    return (lane_w > 0) && (lane_w <= PAR_MAX_W) && (data_w % lane_w == 0);
  endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear sequencer: walks every address once after reset or on init,
// and holds busy while doing so.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // state    | meaning
  // ST_CLEAR | zeroing MEM[clr_ptr] each edge, accesses ignored
  // ST_IDLE  | normal read/write service, init restarts the clear

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == {ADDR_W{1'b1}}) state <= ST_IDLE;
        end
        default: begin
          if (init) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/ram_sp_clr.sv
// Parametrised single-port RAM with lane write masks, registered read
// with valid strobe, and hardware clear. Optional parity: RAM_PARITY_EN.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LANE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          idata,
  input  logic [DATA_W/LANE_W-1:0]   wmask,
  input  logic                       init,
  output logic [DATA_W-1:0]          odata,
  output logic                       ovalid,
  output logic                       busy,
  output logic                       perr
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  if (!lane_cfg_ok(DATA_W, LANE_W)) begin : g_cfg_err
    $error("ram_sp_clr: DATA_W must be a multiple of LANE_W");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic              rd_perr;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // init wins over a same-cycle access; the access is simply dropped.
  assign acc    = en & ~busy & ~init;
  assign wr_acc = acc & wr;
  assign rd_acc = acc & ~wr;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wmask[i]) mem[addr][i*LANE_W +: LANE_W] <= idata[i*LANE_W +: LANE_W];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NLANES-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wmask[i]) par_mem[addr][i] <= lane_parity(PAR_MAX_W'(idata[i*LANE_W +: LANE_W]));
      end
    end
  end

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_parity(PAR_MAX_W'(mem[addr][i*LANE_W +: LANE_W])) != par_mem[addr][i]) rd_perr = 1'b1;
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      odata  <= '0;
      ovalid <= 1'b0;
      perr   <= 1'b0;
    end else begin
      ovalid <= rd_acc;
      perr   <= rd_acc & rd_perr;
      if (rd_acc) odata <= mem[addr];
    end
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Self-checking bench for ram_sp_clr (DATA_W=8, ADDR_W=4, LANE_W=4):
// behavioural model compared every cycle plus directed literal checks.
module tb_ram_sp_clr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       wr = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] idata = '0;
  logic [1:0] wmask = '0;
  logic       init = 1'b0;
  logic [7:0] odata;
  logic       ovalid;
  logic       busy;
  logic       perr;

  int n_checks = 0;
  int n_errors = 0;

  ram_sp_clr #(.DATA_W(8), .ADDR_W(4), .LANE_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .wr     (wr),
    .addr   (addr),
    .idata  (idata),
    .wmask  (wmask),
    .init   (init),
    .odata  (odata),
    .ovalid (ovalid),
    .busy   (busy),
    .perr   (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: clear is a countdown of remaining words; memory is a plain array.
  int         m_clr_left = 16;
  logic [7:0] m_mem [16];
  bit         m_bad [16];
  logic [7:0] m_odata = '0;
  logic       m_ovalid = 1'b0;
  logic       m_perr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clr_left = 16;
      m_odata    = '0;
      m_ovalid   = 1'b0;
      m_perr     = 1'b0;
    end else if (m_clr_left > 0) begin
      m_mem[16 - m_clr_left] = 8'h00;
      m_bad[16 - m_clr_left] = 1'b0;
      m_clr_left = m_clr_left - 1;
      m_ovalid = 1'b0;
      m_perr   = 1'b0;
    end else if (init) begin
      m_clr_left = 16;
      m_ovalid = 1'b0;
      m_perr   = 1'b0;
    end else if (en && wr) begin
      if (wmask[0]) begin
        m_mem[addr][3:0] = idata[3:0];
        m_bad[addr] = 1'b0;
      end
      if (wmask[1]) m_mem[addr][7:4] = idata[7:4];
      m_ovalid = 1'b0;
      m_perr   = 1'b0;
    end else if (en) begin
      m_odata  = m_mem[addr];
      m_ovalid = 1'b1;
      m_perr   = m_bad[addr];
    end else begin
      m_ovalid = 1'b0;
      m_perr   = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_odata", odata, m_odata);
    chk("model_ovalid", ovalid, m_ovalid);
    chk("model_busy", busy, m_clr_left > 0);
    chk("model_perr", perr, m_perr);
  end

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] m);
    en = 1'b1; wr = 1'b1; addr = a; idata = d; wmask = m;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input string nm, input logic [7:0] exp_d);
    en = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    chk({nm, "_odata"}, odata, exp_d);
    chk({nm, "_ovalid"}, ovalid, 1'b1);
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, 16);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_odata", odata, 8'h00);
    chk("reset_ovalid", ovalid, 1'b0);
    chk("reset_busy", busy, 1'b1);
    // Write request held through the whole post-reset clear must be ignored.
    en = 1'b1; wr = 1'b1; addr = 4'd2; idata = 8'hFF; wmask = 2'b11;
    rst = 1'b1;
    wait_clear("reset_clear_edges");
    en = 1'b0; wr = 1'b0;

    en = 1'b1; wr = 1'b0;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      @(negedge clk);
      chk("sweep_odata", odata, 8'h00);
      chk("sweep_ovalid", ovalid, 1'b1);
    end
    en = 1'b0;
    @(negedge clk);
    chk("sweep_end_ovalid", ovalid, 1'b0);

    do_write(4'd5, 8'hA3, 2'b11);
    chk("write_no_ovalid", ovalid, 1'b0);
    do_read(4'd5, "full_write", 8'hA3);
    chk("full_write_perr", perr, 1'b0);
    @(negedge clk);
    chk("strobe_one_cycle", ovalid, 1'b0);

    do_write(4'd5, 8'h5C, 2'b01);
    do_read(4'd5, "low_lane", 8'hAC);
    do_write(4'd5, 8'h00, 2'b00);
    do_read(4'd5, "mask_zero", 8'hAC);
    do_write(4'd5, 8'h9F, 2'b10);
    do_read(4'd5, "high_lane", 8'h9C);
    do_read(4'd2, "busy_write_dropped", 8'h00);

    do_write(4'd15, 8'h7E, 2'b11);
    do_read(4'd15, "pre_init", 8'h7E);
    en = 1'b1; wr = 1'b0; addr = 4'd15; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init_drop_ovalid", ovalid, 1'b0);
    chk("init_busy", busy, 1'b1);
    wait_clear("init_clear_edges");
    en = 1'b0;
    do_read(4'd15, "post_init", 8'h00);

    do_write(4'd0, 8'h11, 2'b11);
    do_write(4'd5, 8'hA3, 2'b11);
    do_read(4'd5, "pre_async", 8'hA3);
    #2 rst = 1'b0;
    #1;
    chk("async_odata", odata, 8'h00);
    chk("async_ovalid", ovalid, 1'b0);
    chk("async_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_clear("async_clear_edges");
    do_read(4'd0, "async_clr0", 8'h00);
    do_read(4'd5, "async_clr5", 8'h00);

`ifdef RAM_PARITY_EN
    do_write(4'd3, 8'h3C, 2'b11);
    do_read(4'd3, "par_clean", 8'h3C);
    chk("par_clean_perr", perr, 1'b0);
    dut.par_mem[3][0] = ~dut.par_mem[3][0];
    m_bad[3] = 1'b1;
    do_read(4'd3, "par_flip", 8'h3C);
    chk("par_flip_perr", perr, 1'b1);
    do_read(4'd5, "par_other", 8'h00);
    chk("par_other_perr", perr, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
Parametrised single-port synchronous RAM, successor to the team's fixed 4x16 RAM. Adds generic width and depth, per-lane write masks, a read-valid strobe, and a hardware clear engine that zeroes the whole array after reset or on request. Sits as local scratch storage behind a simple en/wr request interface.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of LANE_W.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
LANE_W, 4, write-mask granularity in bits; NLANES = DATA_W/LANE_W.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  access request; sampled only while busy=0.
wr  in  1  1 = write, 0 = read; qualified by en.
addr  in  ADDR_W  word address.
idata  in  DATA_W  write data.
wmask  in  NLANES  per-lane write enable; bit i covers idata[i*LANE_W +: LANE_W].
init  in  1  single-cycle request to re-clear the array.
odata  out  DATA_W  read data; registered.
ovalid  out  1  one-cycle strobe: odata was updated by a read.
busy  out  1  clear engine active; accesses are ignored.
perr  out  1  parity error on the current read; valid with ovalid.

Behaviour:
- rst low, at any time and asynchronously: state=CLEAR, clr_ptr=0, odata=0, ovalid=0, busy=1, perr=0. The array is not reset directly; the clear engine zeroes it.
- FSM states are CLEAR and IDLE.
- CLEAR, each edge: MEM[clr_ptr]<=0, then clr_ptr++. After writing DEPTH-1, the next state is IDLE and busy goes 0 on the same edge. Total: exactly DEPTH edges after rst is released.
- In CLEAR: en, wr and init are ignored. There are no writes and no reads, ovalid stays 0, and odata holds its value.
- IDLE, init=1: the next state is CLEAR with clr_ptr=0 and busy=1. init takes priority over en in the same cycle; that access is dropped and ovalid stays 0.
- IDLE, en=1, wr=1: for each lane i with wmask[i]=1, write that lane of MEM[addr]. Other lanes keep their values. With wmask=0, nothing changes. odata holds its value and ovalid=0.
- IDLE, en=1, wr=0: odata<=MEM[addr] and ovalid<=1, giving 1-cycle latency. Back-to-back reads give ovalid high continuously.
- IDLE, en=0: ovalid<=0 and odata holds its value.
- A read in the cycle after a write to the same address returns the new data. No same-cycle read-during-write exists, because the port is single.
- Address wrap: none. addr is exactly ADDR_W bits, so every value is a valid address.

Optional Feature:
Macro: RAM_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, written with that lane's data. A partial write updates only the written lanes' parity.
  - The clear engine writes zero data and zero parity.
  - On a read, perr<=1 together with ovalid if any lane's stored parity mismatches its stored data; otherwise perr<=0.
  - A bench hook lets the test flip a stored parity bit.
- Undefined: no parity storage, and perr is tied to 0.

Decomposition:
- Package ram_pkg holds:
  - the state typedef (ST_CLEAR, ST_IDLE);
  - a lane-parity function;
  - an elaboration check that DATA_W % LANE_W == 0.
- One sub-module is natural: ram_clr_fsm, holding the state register, clr_ptr and busy. It outputs the clear write-enable and address to the top level, which holds the array and the read path.

Test Plan (DATA_W=8, ADDR_W=4, LANE_W=4):
1. Hold rst low for 3 cycles, then release. Required: odata=0x00, ovalid=0 and busy=1 for exactly 16 edges, then busy=0. Reading addresses 0..15 back-to-back then gives 0x00 each time, with ovalid high for 16 consecutive cycles.
2. Write addr=5, idata=0xA3, wmask=2'b11, then read addr=5. Required: one cycle after the read, odata=0xA3, ovalid=1 for one cycle, perr=0.
3. Write addr=5, idata=0x5C, wmask=2'b01, then read addr=5. Required: odata=0xAC, because only the low lane is updated.
4. During busy, request en=1, wr=1, addr=2, idata=0xFF. Required: write ignored; after busy falls, reading addr=2 gives 0x00. A read request during busy gives no ovalid.
5. Write addr=15 with 0x7E, then pulse init in the same cycle as en=1, wr=0, addr=15. Required: no ovalid on that cycle, busy=1 for 16 edges, then reading addr=15 gives 0x00.
6. Drop rst low asynchronously between edges in the cycle after a read, with ovalid=1 and odata=0xA3. Required: odata=0x00, ovalid=0 and busy=1 immediately, and after release the clear restarts from address 0. With RAM_PARITY_EN defined, flip the parity bit of addr=3; reading addr=3 then gives perr=1.
